switch_out_arbiter: RTL and testbench

SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

---
 rtl/switch_out_arbiter.sv | 83 ++++++++
 tb/tb_switch_out_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter: round-robin packet arbiter draining length-prefixed packets from show-ahead port FIFOs
// into a single registered valid/ready output stream.
module switch_out_arbiter #(
  parameter int NUM_OF_PORTS = 4,
  parameter int W_WIDTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_OF_PORTS-1:0]         port_empty,
  input  logic [NUM_OF_PORTS*W_WIDTH-1:0] port_data,
  output logic [NUM_OF_PORTS-1:0]         port_rd,
  output logic [W_WIDTH-1:0]              out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [NUM_OF_PORTS-1:0]         grant,
  output logic                            busy
);
  localparam int IW = NUM_OF_PORTS > 1 ? $clog2(NUM_OF_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
  state_t                    r_state, w_next;
  logic [IW-1:0]             r_gidx, r_last, w_sel;
  logic [NUM_OF_PORTS-1:0]   r_grant;
  logic [W_WIDTH-1:0]        r_cnt, r_data, w_head;
  logic                      r_valid, r_sop, r_eop;
  logic                      w_any, w_load, w_pop, w_end;
  assign w_any  = ~&port_empty;
  assign w_load = !r_valid || out_ready;
  assign w_head = port_data[int'(r_gidx)*W_WIDTH +: W_WIDTH];
  assign w_pop  = r_state != IDLE && !port_empty[r_gidx] && w_load;
  assign w_end  = w_pop && (r_state == HDR ? w_head == '0 : r_cnt == W_WIDTH'(1));
  // Highest offset first so the closest port after last_grant wins.
  always_comb begin
    w_sel = r_last;
    for (int i = NUM_OF_PORTS; i >= 1; i--)
      if (!port_empty[(int'(r_last) + i) % NUM_OF_PORTS]) w_sel = IW'((int'(r_last) + i) % NUM_OF_PORTS);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_any ? HDR : IDLE) : w_end ? IDLE : w_pop ? XFER : r_state;
  always_comb begin
    port_rd = w_pop ? r_grant : '0;
    busy    = r_state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_OF_PORTS - 1);
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= NUM_OF_PORTS'(1) << w_sel;
        r_gidx  <= w_sel;
      end
      if (w_end) begin
        r_grant <= '0;
        r_last  <= r_gidx;
      end
      if (w_pop) begin
        r_data  <= w_head;
        r_valid <= 1'b1;
        r_sop   <= r_state == HDR;
        r_eop   <= w_end;
        r_cnt   <= r_state == HDR ? w_head : r_cnt - W_WIDTH'(1);
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign grant     = r_grant;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sop   = r_sop;
  assign out_eop   = r_eop;
endmodule

// File: tb/tb_switch_out_arbiter.sv
// tb_switch_out_arbiter: bench FIFOs as queues, a packet-level model (owner/words-left) checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_switch_out_arbiter;
  localparam int N = 4, W = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0]   port_empty, port_rd, grant;
  logic [N*W-1:0] port_data;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready, out_sop, out_eop, busy;
  always #5 clk = ~clk;
  switch_out_arbiter #(.NUM_OF_PORTS(N), .W_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .port_empty(port_empty), .port_data(port_data), .port_rd(port_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .grant(grant), .busy(busy));
  logic [W-1:0] q [N][$];
  int owner, left, last;
  bit hdr, mv, ms, me;
  logic [W-1:0] md;
  int errs = 0, checks = 0;
  logic [W-1:0] acc [$];
  bit acc_s [$], acc_e [$];
  int gord [$];
  int rdcnt [N];
  logic [N-1:0] prev_g = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      port_empty[i] = q[i].size() == 0;
      port_data[i*W +: W] = q[i].size() > 0 ? q[i][0] : '0;
    end
  endtask
  task automatic mreset();
    owner = -1; left = 0; last = N - 1; hdr = 0; mv = 0; ms = 0; me = 0; md = '0;
    for (int i = 0; i < N; i++) q[i].delete();
  endtask
  task automatic clear_log();
    acc.delete(); acc_s.delete(); acc_e.delete(); gord.delete();
    for (int i = 0; i < N; i++) rdcnt[i] = 0;
  endtask
  task automatic push_pkt(input int p, input int len, input int base);
    q[p].push_back(W'(len));
    for (int k = 0; k < len; k++) q[p].push_back(W'(base + k));
  endtask
  task automatic compare();
    logic [N-1:0] eg, erd;
    eg  = owner >= 0 ? N'(1) << owner : '0;
    erd = (owner >= 0 && q[owner].size() > 0 && (!mv || out_ready)) ? eg : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("port_rd", 32'(port_rd), 32'(erd));
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv) begin
      chk("out_data", 32'(out_data), 32'(md));
      chk("out_sop", 32'(out_sop), 32'(ms));
      chk("out_eop", 32'(out_eop), 32'(me));
    end
    if (out_valid && out_ready) begin
      acc.push_back(out_data); acc_s.push_back(out_sop); acc_e.push_back(out_eop);
    end
    for (int i = 0; i < N; i++) begin
      if (port_rd[i]) rdcnt[i]++;
      if (grant[i] && prev_g == '0) gord.push_back(i);
    end
    prev_g = grant;
  endtask
  task automatic model_edge();
    bit pop;
    logic [W-1:0] w;
    pop = owner >= 0 && q[owner].size() > 0 && (!mv || out_ready);
    if (owner < 0) begin
      for (int i = N; i >= 1; i--)
        if (q[(last + i) % N].size() > 0) owner = (last + i) % N;
      if (owner >= 0) hdr = 1;
    end else if (pop) begin
      w = q[owner].pop_front();
      md = w; mv = 1;
      if (hdr) begin
        ms = 1; left = int'(w); hdr = 0;
      end else begin
        ms = 0; left--;
      end
      me = left == 0;
      if (left == 0) begin
        last = owner; owner = -1;
      end
    end
    if (!pop && out_ready) mv = 0;
  endtask
  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1 refresh();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_data"}, 32'(out_data), 0);
    chk({nm, "_sop_eop"}, 32'({out_sop, out_eop}), 0);
    chk({nm, "_port_rd"}, 32'(port_rd), 0);
  endtask
  task automatic do_reset();
    rst = 1;
    mreset();
    refresh();
    @(posedge clk);
    #1 rst = 0;
    prev_g = '0;
  endtask
  initial begin
    int p;
    out_ready = 1;
    mreset();
    refresh();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 0;
    // single packet on port 1
    clear_log();
    push_pkt(1, 3, 8'hA1);
    refresh();
    run(10);
    chk("single_len", acc.size(), 4);
    if (acc.size() == 4) begin
      chk("single_w0", 32'(acc[0]), 3);
      chk("single_w1", 32'(acc[1]), 32'hA1);
      chk("single_w3", 32'(acc[3]), 32'hA3);
      chk("single_sop", 32'({acc_s[0], acc_s[1], acc_s[2], acc_s[3]}), 32'b1000);
      chk("single_eop", 32'({acc_e[0], acc_e[1], acc_e[2], acc_e[3]}), 32'b0001);
    end
    chk("single_rd1", rdcnt[1], 4);
    chk("single_gord", gord.size() == 1 ? gord[0] : -1, 1);
    // zero-length packet on port 0
    clear_log();
    push_pkt(0, 0, 0);
    refresh();
    run(6);
    chk("zero_len", acc.size(), 1);
    if (acc.size() == 1) chk("zero_word", 32'({acc[0], acc_s[0], acc_e[0]}), 32'h003);
    chk("zero_rd0", rdcnt[0], 1);
    // round-robin from a fresh reset
    do_reset();
    clear_log();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, 16 * i + k);
    refresh();
    run(50);
    chk("rr_count", gord.size(), 8);
    for (int k = 0; k < 8; k++) chk("rr_order", k < gord.size() ? gord[k] : -1, k % N);
    // backpressure mid-packet
    clear_log();
    push_pkt(2, 4, 8'h50);
    refresh();
    run(3);
    out_ready = 0;
    run(3);
    out_ready = 1;
    run(10);
    chk("bp_len", acc.size(), 5);
    for (int k = 1; k < 5; k++) chk("bp_word", k < acc.size() ? 32'(acc[k]) : 0, 32'h50 + k - 1);
    // starvation mid-packet on port 2 (last_grant is 2 here, so fill port 2 alone first)
    clear_log();
    q[2].push_back(8'd5); q[2].push_back(8'h61); q[2].push_back(8'h62);
    refresh();
    run(2);
    push_pkt(3, 1, 8'h30); push_pkt(0, 1, 8'h00); push_pkt(1, 1, 8'h10);
    refresh();
    run(8);
    chk("starve_grant", 32'(grant), 32'b0100);
    q[2].push_back(8'h63); q[2].push_back(8'h64); q[2].push_back(8'h65);
    refresh();
    run(30);
    for (int k = 1; k < 6; k++) chk("starve_word", k < acc.size() ? 32'(acc[k]) : 0, 32'h60 + k);
    chk("starve_gord", gord.size() == 4 ? 32'({gord[0][3:0], gord[1][3:0], gord[2][3:0], gord[3][3:0]}) : 0, 32'h2301);
    // asynchronous reset during XFER
    push_pkt(3, 6, 8'h70);
    refresh();
    run(4);
    #2 rst = 1;
    #1 chk_reset_vals("async_rst");
    mreset();
    refresh();
    @(posedge clk);
    #1 rst = 0;
    prev_g = '0;
    clear_log();
    push_pkt(1, 1, 8'h11); push_pkt(0, 1, 8'h01);
    refresh();
    run(12);
    chk("post_rst_first", gord.size() > 0 ? gord[0] : -1, 0);
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(0, N - 1));
        if (q[p].size() < 30) push_pkt(p, int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
        refresh();
      end
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    out_ready = 1;
    run(300);
    chk("drain_idle", owner, -1);
    for (int i = 0; i < N; i++) chk("drain_empty", q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
